// File: rtl/aes_inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine: BPC inverse-S-box lanes sweep a latched 128-bit state in 16/BPC cycles.
// Optional macro AES_INV_SHIFTROWS_EN folds InvShiftRows into the result-register write.

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  always_comb begin
    y = 8'h00;
    case (a)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
    endcase
  end
endmodule

module aes_inv_sub_bytes_seq #(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  localparam int N  = 16 / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [127:0]        src_q, src_d, res_q, res_d;
  logic [BPC-1:0][7:0] lane_in, lane_out;

  genvar g;
  generate
    for (g = 0; g < BPC; g++) begin : g_lane
      aes_inv_sbox u_sbox (.a(lane_in[g]), .y(lane_out[g]));
    end
  endgenerate

  // Result byte slot for source byte b; with InvShiftRows, (r,c) moves to (r,(c+r) mod 4).
  function automatic int dest_idx(input int b);
`ifdef AES_INV_SHIFTROWS_EN
    return (((b / 4) + (b % 4)) % 4) * 4 + (b % 4);
`else
    return b;
`endif
  endfunction

  always_comb begin
    for (int l = 0; l < BPC; l++)
      lane_in[l] = src_q[127 - 8 * (int'(cnt_q) * BPC + l) -: 8];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        src_d   = in_data;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        for (int l = 0; l < BPC; l++)
          res_d[127 - 8 * dest_idx(int'(cnt_q) * BPC + l) -: 8] = lane_out[l];
        if (cnt_q == CW'(N - 1)) state_d = DONE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  // Held low during reset so nothing can be accepted while flops are cleared.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = res_q;
endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Bench for aes_inv_sub_bytes_seq: four lane widths side by side, checked against a GF(2^8)-derived S-box model.
module tb_aes_inv_sub_bytes_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic [3:0]   ir, ov;
  logic [127:0] od [4];

  int n_chk = 0, n_pass = 0;
  logic [7:0]   fwd [256];
  logic [7:0]   inv [256];
  int           lat_exp [4] = '{4, 16, 8, 1};
  int           got_lat [4];
  logic [127:0] got_d [4];

  typedef struct { logic [127:0] din; logic [127:0] dout; } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  aes_inv_sub_bytes_seq #(.BPC(4)) u_b4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]));
  aes_inv_sub_bytes_seq #(.BPC(1)) u_b1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]));
  aes_inv_sub_bytes_seq #(.BPC(2)) u_b2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]));
  aes_inv_sub_bytes_seq #(.BPC(16)) u_b16 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] fsbox(input int x);
    logic [7:0] v;
    v = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] o;
    int sc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
`ifdef AES_INV_SHIFTROWS_EN
        sc = (c - r + 4) % 4;
`else
        sc = c;
`endif
        o[127 - 8 * (c * 4 + r) -: 8] = inv[d[127 - 8 * (sc * 4 + r) -: 8]];
      end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (ir !== 4'hf && k < 60) begin @(posedge clk); #1; k++; end
    if (ir !== 4'hf) chk("ready_timeout", 128'(ir), 128'hf);
  endtask

  task automatic run_txn(input logic [127:0] d);
    wait_ready();
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) begin got_lat[i] = 0; got_d[i] = '0; end
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (ov[i] && got_lat[i] == 0) begin got_lat[i] = cyc; got_d[i] = od[i]; end
      if (got_lat[0] != 0 && got_lat[1] != 0 && got_lat[2] != 0 && got_lat[3] != 0) break;
    end
  endtask

  task automatic check_txn(input string nm, input logic [127:0] exp);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_data_u%0d", nm, i), got_d[i], exp);
      chk($sformatf("%s_lat_u%0d", nm, i), 128'(got_lat[i]), 128'(lat_exp[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d, e;
    for (int x = 0; x < 256; x++) begin fwd[x] = fsbox(x); inv[fwd[x]] = 8'(x); end

    vecs[0] = '{din: {16{8'h63}}, dout: 128'h0};
`ifdef AES_INV_SHIFTROWS_EN
    vecs[1] = '{din: 128'h000102030405060708090a0b0c0d0e0f, dout: 128'h52f3a338_3009d79e_bf366afb_8140a5d5};
`else
    vecs[1] = '{din: 128'h000102030405060708090a0b0c0d0e0f, dout: 128'h52096ad53036a538bf40a39e81f3d7fb};
`endif
    vecs[2] = '{din: {16{8'h52}}, dout: {16{8'h48}}};
    vecs[3] = '{din: {16{8'hff}}, dout: {16{8'h7d}}};

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 128'(ir), 128'h0);
    chk("rst_out_valid", 128'(ov), 128'h0);
    chk("rst_out_data", od[0], 128'h0);
    rst_n = 1'b1; #1;
    chk("rst_release_ready", 128'(ir), 128'hf);

    foreach (vecs[v]) begin
      run_txn(vecs[v].din);
      check_txn($sformatf("vec%0d", v), vecs[v].dout);
    end

    // Every byte value through every lane position
    for (int x = 0; x < 256; x++) begin
      for (int b = 0; b < 16; b++) d[127 - 8 * b -: 8] = fwd[(x + b * 17) & 255];
      run_txn(d);
      check_txn($sformatf("exh%0d", x), model(d));
    end

    for (int t = 0; t < 30; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_txn(d);
      check_txn($sformatf("rnd%0d", t), model(d));
    end

    // Back-pressure in DONE
    wait_ready();
    out_ready = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    e = model(d);
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~d;
    repeat (3) @(posedge clk); #1;
    chk("bp_valid_early", 128'(ov[0]), 128'h0);
    @(posedge clk); #1;
    chk("bp_valid_rise", 128'(ov[0]), 128'h1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_valid%0d", k), 128'(ov[0]), 128'h1);
      chk($sformatf("bp_hold_data%0d", k), od[0], e);
      chk($sformatf("bp_hold_ready%0d", k), 128'(ir[0]), 128'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 128'(ir[0]), 128'h1);
    chk("bp_release_valid", 128'(ov[0]), 128'h0);
    chk("bp_idle_hold_data", od[0], e);

    // Reset during BUSY
    wait_ready();
    d = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0; #2;
    chk("midrst_valid", 128'(ov), 128'h0);
    chk("midrst_ready", 128'(ir), 128'h0);
    chk("midrst_data", od[0], 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    chk("midrst_release_ready", 128'(ir), 128'hf);
    chk("midrst_release_valid", 128'(ov), 128'h0);
    d = {$urandom, $urandom, $urandom, $urandom};
    run_txn(d);
    check_txn("post_rst", model(d));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
